// File: rtl/night_rider_monitor_pkg.sv
// Shared types for the night-rider scanner monitor: FSM state encoding and
// error-cause codes reported on err_code.
package night_rider_monitor_pkg;

  localparam int unsigned ERR_W = 2;

  typedef enum logic [1:0] {
    ST_ACQUIRE    = 2'b00,
    ST_TRACK_UP   = 2'b01,
    ST_TRACK_DOWN = 2'b10
  } state_t;

  // 2'b11 is reserved and never produced.
  typedef enum logic [ERR_W-1:0] {
    ERR_NONE       = 2'b00,
    ERR_NOT_ONEHOT = 2'b01,
    ERR_BAD_STEP   = 2'b10
  } err_code_t;

endpackage

// File: rtl/night_rider_monitor_onehot_decode.sv
// onehot_decode: combinational one-hot to binary index decoder.
//   led_in    : N-bit vector, bit k lit means position k
//   idx       : binary index of the lit bit (meaningful only when onehot_ok)
//   onehot_ok : exactly one bit of led_in is set
module onehot_decode #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         led_in,
  output logic [$clog2(N)-1:0] idx,
  output logic                 onehot_ok
);

  localparam int unsigned IDX_W = $clog2(N);

  // OR of the indices of all set bits; exact when the input is one-hot.
  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (led_in[k]) idx = idx | IDX_W'(k);
    end
  end

  assign onehot_ok = $onehot(led_in);

endmodule

// File: rtl/night_rider_monitor.sv
// night_rider_monitor: tracks a back-and-forth one-hot LED scan
// (0,1,..,N-1,N-2,..,1,0,1,..) and flags sequence violations.
//   clk, rst   : clock, synchronous active-high reset
//   led_in     : scanner LED vector, sampled when led_valid is high
//   pos, dir   : last accepted position and sweep direction (1 = upward)
//   locked     : tracking a legal sequence
//   upd, err   : single-cycle pulses for an accepted step / a violation
//   err_code   : cause of the most recent err (held)
//   sweep_cnt  : saturating count of completed round trips
// All outputs are registered, one cycle after the sampled led_in.
module night_rider_monitor
  import night_rider_monitor_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         led_in,
  input  logic                 led_valid,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 locked,
  output logic                 upd,
  output logic                 err,
  output logic [ERR_W-1:0]     err_code,
  output logic [CNT_W-1:0]     sweep_cnt
);

  localparam int unsigned      IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic               onehot_ok;
  logic [IDX_W-1:0]   expect_idx;
  logic               step_ok;

  logic [IDX_W-1:0]   pos_d;
  logic               dir_d, locked_d, upd_d, err_d;
  logic [ERR_W-1:0]   err_code_d;
  logic [CNT_W-1:0]   sweep_cnt_d;

  onehot_decode #(.N(N)) u_decode (
    .led_in    (led_in),
    .idx       (idx),
    .onehot_ok (onehot_ok)
  );

  // Expected next position; guarded so pos never wraps at either end.
  always_comb begin
    expect_idx = pos;
    if (state_q == ST_TRACK_UP && pos != IDX_LAST) begin
      expect_idx = pos + IDX_W'(1);
    end else if (state_q == ST_TRACK_DOWN && pos != '0) begin
      expect_idx = pos - IDX_W'(1);
    end
  end

  assign step_ok = onehot_ok && (idx == expect_idx);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACQUIRE;
      pos       <= '0;
      dir       <= 1'b1;
      locked    <= 1'b0;
      upd       <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      sweep_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pos       <= pos_d;
      dir       <= dir_d;
      locked    <= locked_d;
      upd       <= upd_d;
      err       <= err_d;
      err_code  <= err_code_d;
      sweep_cnt <= sweep_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (led_valid) begin
      unique case (state_q)
        ST_ACQUIRE: begin
          if (onehot_ok && idx == '0)            state_d = ST_TRACK_UP;
          else if (onehot_ok && idx == IDX_LAST) state_d = ST_TRACK_DOWN;
        end
        ST_TRACK_UP: begin
          if (!step_ok)              state_d = ST_ACQUIRE;
          else if (idx == IDX_LAST)  state_d = ST_TRACK_DOWN;
        end
        ST_TRACK_DOWN: begin
          if (!step_ok)              state_d = ST_ACQUIRE;
          else if (idx == '0)        state_d = ST_TRACK_UP;
        end
        default: state_d = ST_ACQUIRE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    pos_d       = pos;
    dir_d       = dir;
    locked_d    = locked;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code;
    sweep_cnt_d = sweep_cnt;
    if (led_valid) begin
      if (state_q == ST_ACQUIRE) begin
        if (state_d != ST_ACQUIRE) begin
          pos_d    = idx;
          dir_d    = (state_d == ST_TRACK_UP);
          locked_d = 1'b1;
          upd_d    = 1'b1;
        end
      end else if (!step_ok) begin
        // Violation: drop lock, hold pos/dir.
        err_d      = 1'b1;
        locked_d   = 1'b0;
        err_code_d = onehot_ok ? ERR_BAD_STEP : ERR_NOT_ONEHOT;
      end else begin
        pos_d = idx;
        dir_d = (state_d == ST_TRACK_UP);
        upd_d = 1'b1;
        // Returning to 0 completes a round trip.
        if (state_q == ST_TRACK_DOWN && state_d == ST_TRACK_UP &&
            sweep_cnt != {CNT_W{1'b1}}) begin
          sweep_cnt_d = sweep_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_night_rider_monitor.sv
// Scoreboard bench for night_rider_monitor: stimulus pushes the expected
// post-edge outputs of a behavioural model; a monitor pops and compares.
module tb_night_rider_monitor;

  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   led_in;
  logic           led_valid;

  logic [2:0]     pos, pos_s;
  logic           dir, locked, upd, err;
  logic           dir_s, locked_s, upd_s, err_s;
  logic [1:0]     err_code, err_code_s;
  logic [15:0]    sweep_cnt;
  logic [1:0]     sweep_cnt_s;

  always #5 clk = ~clk;

  night_rider_monitor #(.N(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .led_in(led_in), .led_valid(led_valid),
    .pos(pos), .dir(dir), .locked(locked), .upd(upd), .err(err),
    .err_code(err_code), .sweep_cnt(sweep_cnt)
  );

  night_rider_monitor #(.N(N), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .led_in(led_in), .led_valid(led_valid),
    .pos(pos_s), .dir(dir_s), .locked(locked_s), .upd(upd_s), .err(err_s),
    .err_code(err_code_s), .sweep_cnt(sweep_cnt_s)
  );

  typedef struct packed {
    logic [2:0]  pos;
    logic        dir;
    logic        locked;
    logic        upd;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
  } obs_t;

  obs_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Behavioural model state.
  int   m_pos    = 0;
  bit   m_dir    = 1'b1;
  bit   m_locked = 1'b0;
  int   m_code   = 0;
  int   m_cnt    = 0;

  function automatic int next_want();
    return m_dir ? m_pos + 1 : m_pos - 1;
  endfunction

  // Apply one cycle of stimulus and queue the model's expected outputs.
  task automatic step(input bit r, input bit v, input logic [N-1:0] l);
    obs_t e;
    int   ones;
    int   k;
    @(negedge clk);
    rst = r; led_valid = v; led_in = l;
    e.upd = 1'b0;
    e.err = 1'b0;
    if (r) begin
      m_pos = 0; m_dir = 1'b1; m_locked = 1'b0; m_code = 0; m_cnt = 0;
    end else if (v) begin
      ones = $countones(l);
      k = -1;
      if (ones == 1) for (int i = 0; i < N; i++) if (l[i]) k = i;
      if (!m_locked) begin
        if (k == 0) begin
          m_locked = 1'b1; m_dir = 1'b1; m_pos = 0; e.upd = 1'b1;
        end else if (k == N - 1) begin
          m_locked = 1'b1; m_dir = 1'b0; m_pos = N - 1; e.upd = 1'b1;
        end
      end else if (ones != 1) begin
        e.err = 1'b1; m_code = 1; m_locked = 1'b0;
      end else if (k != next_want()) begin
        e.err = 1'b1; m_code = 2; m_locked = 1'b0;
      end else begin
        m_pos = k; e.upd = 1'b1;
        if (k == N - 1) m_dir = 1'b0;
        else if (k == 0) begin m_dir = 1'b1; m_cnt++; end
      end
    end
    e.pos      = 3'(m_pos);
    e.dir      = m_dir;
    e.locked   = m_locked;
    e.err_code = 2'(m_code);
    e.cnt16    = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt2     = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    q.push_back(e);
  endtask

  task automatic at(input int p);
    logic [N-1:0] l;
    l = N'(1) << p;
    step(1'b0, 1'b1, l);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, N'($urandom));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, N'($urandom));
  endtask

  // Monitor: outputs are present every cycle; compare 1 time unit after the edge.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{pos, dir, locked, upd, err, err_code, sweep_cnt, sweep_cnt_s};
        compared++;
        if (a !== e || pos_s !== pos || dir_s !== dir || locked_s !== locked ||
            upd_s !== upd || err_s !== err || err_code_s !== err_code) begin
          mismatched++;
          $display("FAIL outputs t=%0t: got pos=%0d dir=%0b locked=%0b upd=%0b err=%0b code=%0d cnt=%0d cnt2=%0d (sat pos=%0d) want pos=%0d dir=%0b locked=%0b upd=%0b err=%0b code=%0d cnt=%0d cnt2=%0d",
                   $time, a.pos, a.dir, a.locked, a.upd, a.err, a.err_code, a.cnt16, a.cnt2, pos_s,
                   e.pos, e.dir, e.locked, e.upd, e.err, e.err_code, e.cnt16, e.cnt2);
        end
      end
    end
  end

  initial begin
    int           p;
    int           w;
    logic [N-1:0] l;
    rst = 1'b1; led_valid = 1'b0; led_in = '0;

    // Scanner run 0..7..0..7.
    do_reset();
    for (int i = 0; i < N; i++) at(i);
    for (int i = N - 2; i >= 0; i--) at(i);
    for (int i = 1; i < N; i++) at(i);
    idle();

    // Same run with valid every third cycle.
    do_reset();
    for (int i = 0; i < 3 * N - 2; i++) begin
      at((i < N) ? i : ((i < 2 * N - 1) ? 2 * N - 2 - i : i - 2 * N + 2));
      idle(); idle();
    end

    // Mid-start: 3,4,5 ignored, lock on 7.
    do_reset();
    at(3); at(4); at(5); at(7); at(6);

    // Zero-hot fault while locked, then a skipped step.
    do_reset();
    at(0); at(1); step(1'b0, 1'b1, '0); idle();
    do_reset();
    at(0); at(1); at(3); at(2);
    // Repeated position and multi-hot.
    at(0); at(1); at(1);
    at(7); step(1'b0, 1'b1, 8'h30);

    // Reset mid-sweep at pos 5, then 6 is ignored.
    do_reset();
    for (int i = 0; i <= 5; i++) at(i);
    do_reset();
    at(6); idle();

    // Five round trips: 2-bit counter saturates at 3.
    do_reset();
    at(0);
    for (int t = 0; t < 5; t++) begin
      for (int i = 1; i < N; i++) at(i);
      for (int i = N - 2; i >= 0; i--) at(i);
    end
    at(1); idle();

    // Randomised traffic, mostly legal.
    for (int n = 0; n < 4000; n++) begin
      p = $urandom_range(0, 99);
      if (m_locked) w = next_want();
      else w = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1)
                                           : (($urandom_range(0, 1) == 0) ? 0 : N - 1);
      if (p < 85)      l = N'(1) << w;
      else if (p < 91) l = N'(1) << $urandom_range(0, N - 1);
      else if (p < 95) l = '0;
      else             l = N'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, l);
    end

    // Drain the scoreboard with a bounded wait.
    for (int c = 0; c < 10 && q.size() > 0; c++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
